// File: rtl/alu_defs.sv
// alu_defs: shared op encodings, widths and the serial_nibble_and state type
package alu_defs;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;
  localparam int NIBBLE_W = 4;
  localparam int WORD_W = 32;
  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;
endpackage

// File: rtl/four_bit_logic.sv
// four_bit_logic: combinational AND/OR/XOR/NAND on one 4-bit slice
module four_bit_logic
  import alu_defs::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic [1:0]          op,
  output logic [NIBBLE_W-1:0] y
);
  always_comb begin
    y = op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : ~(a & b);
  end
endmodule

// File: rtl/serial_nibble_and.sv
// serial_nibble_and: applies a logic op slice by slice, LS nibble first, and
// presents the reassembled word with a ready/valid handshake.
module serial_nibble_and #(
  parameter int NIBBLES = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        a_nib,
  input  logic [3:0]        b_nib,
  input  logic [1:0]        op,
  output logic [WORD_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              zero
);
  import alu_defs::state_t;
  import alu_defs::COLLECT;
  import alu_defs::DONE;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] op_q, op_sel;
  logic [3:0] y;
  logic in_xfer, out_xfer, last;
  assign in_ready = state == COLLECT;
  assign out_valid = state == DONE;
  assign zero = ~|out;
  assign in_xfer = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign last = cnt == CW'(NIBBLES - 1);
  // the first slice uses op directly so the whole word sees a single op
  assign op_sel = cnt == '0 ? op : op_q;
  four_bit_logic u_logic (
    .a (a_nib),
    .b (b_nib),
    .op(op_sel),
    .y (y)
  );
  always_comb begin
    state_n = state;
    if (in_xfer && last) state_n = DONE;
    else if (out_xfer) state_n = COLLECT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt <= '0;
      op_q <= 2'b00;
      out <= '0;
    end else begin
      state <= state_n;
      if (in_xfer) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (cnt == '0) op_q <= op;
        out[{cnt, 2'b00} +: 4] <= y;
      end
    end
  end
endmodule

// File: tb/tb_serial_nibble_and.sv
// tb_serial_nibble_and: directed scenario tests for serial_nibble_and
module tb_serial_nibble_and;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0] a_nib, b_nib;
  logic [1:0] op;
  logic [31:0] out;
  int checks = 0;
  int errors = 0;

  serial_nibble_and #(.NIBBLES(8), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_nib(a_nib), .b_nib(b_nib), .op(op), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op0, input logic [1:0] op_rest,
                           input int gap);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a_nib = a[4*i +: 4];
      b_nib = b[4*i +: 4];
      op = i == 0 ? op0 : op_rest;
      tick();
      if (gap > 0 && i < 7) begin
        in_valid = 1'b0;
        a_nib = 4'h0;
        b_nib = 4'h0;
        repeat (gap) tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 00000000", out); end
  endtask

  task automatic test_and_word();
    send_word(32'hF0F0_1234, 32'hFFFF_00FF, 2'b00, 2'b00, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_out_valid got %b exp 1", out_valid); end
    checks++; if (out !== 32'hF0F0_0034) begin errors++; $display("FAIL and_out got %h exp f0f00034", out); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL and_zero got %b exp 0", zero); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL and_in_ready got %b exp 0", in_ready); end
    pop();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL and_after_pop got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; a_nib = 4'h3; b_nib = 4'h5; op = 2'b01;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early_valid slice %0d got %b exp 0", i, out_valid); end
    end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out !== 32'h7777_7777) begin errors++; $display("FAIL latency_word got ov=%b out=%h exp ov=1 out=77777777", out_valid, out); end
    pop();
  endtask

  task automatic test_op_latch();
    send_word(32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 2'b00, 0);
    checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL op_latch_out got %h exp ffffffff", out); end
    pop();
  endtask

  task automatic test_zero_backpressure();
    send_word(32'hAAAA_AAAA, 32'h5555_5555, 2'b00, 2'b00, 0);
    in_valid = 1'b1; a_nib = 4'hF; b_nib = 4'hF; op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== 32'h0 || zero !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL zero_hold cycle %0d got ov=%b out=%h zero=%b ir=%b exp ov=1 out=00000000 zero=1 ir=0", i, out_valid, out, zero, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    pop();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_after_pop got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_gaps();
    send_word(32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 2'b10, 3);
    checks++; if (out_valid !== 1'b1 || out !== 32'hEDCB_A987) begin errors++; $display("FAIL gaps_out got ov=%b out=%h exp ov=1 out=edcba987", out_valid, out); end
    pop();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a_nib = 4'hF; b_nib = 4'hF; op = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got out=%h ov=%b ir=%b exp out=00000000 ov=0 ir=1", out, out_valid, in_ready); end
    send_word(32'h0000_000F, 32'hF000_0000, 2'b01, 2'b01, 0);
    checks++; if (out !== 32'hF000_000F) begin errors++; $display("FAIL rst_mid_or_out got %h exp f000000f", out); end
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out !== 32'h0) begin errors++; $display("FAIL rst_done got ov=%b out=%h exp ov=0 out=00000000", out_valid, out); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_word(32'h1234_5678, 32'h0F0F_0F0F, 2'b00, 2'b00, 0);
    checks++; if (out_valid !== 1'b1 || out !== 32'h0204_0608) begin errors++; $display("FAIL b2b_first got ov=%b out=%h exp ov=1 out=02040608", out_valid, out); end
    in_valid = 1'b1; a_nib = 4'h1; b_nib = 4'h2; op = 2'b01;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_transfer got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    send_word(32'h1111_1111, 32'h2222_2222, 2'b01, 2'b00, 0);
    checks++; if (out_valid !== 1'b1 || out !== 32'h3333_3333) begin errors++; $display("FAIL b2b_second got ov=%b out=%h exp ov=1 out=33333333", out_valid, out); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got ov=%b exp 0", out_valid); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_nib = 4'h0; b_nib = 4'h0; op = 2'b00;
    #1;
    test_reset();
    test_and_word();
    test_latency();
    test_op_latch();
    test_zero_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_nibble_and.md
SERIAL_NIBBLE_AND -- requirements
Module: serial_nibble_and

Interface
REQ-001 Parameter: NIBBLES, default 8, number of 4-bit slices per result word.
REQ-002 Parameter: WORD_W, default 32, result width; SHALL equal 4*NIBBLES.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  a_nib/b_nib/op carry a valid slice.
REQ-006 Port: in_ready  output  1  block accepts a slice this cycle.
REQ-007 Port: a_nib  input  4  operand A slice, least-significant slice first.
REQ-008 Port: b_nib  input  4  operand B slice, least-significant slice first.
REQ-009 Port: op  input  2  logic op: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled on the first slice only.
REQ-010 Port: out  output  WORD_W  reassembled result word.
REQ-011 Port: out_valid  output  1  out holds a complete word.
REQ-012 Port: out_ready  input  1  consumer takes the word this cycle.
REQ-013 Port: zero  output  1  out == 0, valid while out_valid=1.

Function
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-015 FSM states: COLLECT, DONE; reset state COLLECT.
REQ-016 COLLECT: in_ready=1, out_valid=0; DONE: in_ready=0, out_valid=1.
REQ-017 Slice counter cnt, width clog2(NIBBLES), reset 0, increments on each input transfer.
REQ-018 On the input transfer with cnt=0, op SHALL be latched into op_q; later op values are ignored until the next word.
REQ-019 Each input transfer SHALL write f(a_nib,b_nib) into out[4*cnt+3:4*cnt], using op for cnt=0 and op_q otherwise.
REQ-020 Input transfer with cnt=NIBBLES-1: cnt wraps to 0, next state DONE; out_valid rises the following cycle (latency 1 cycle after last slice).
REQ-021 DONE: out, zero, out_valid held stable until output transfer; then next state COLLECT, same edge.
REQ-022 No slice accepted in the cycle of the output transfer (in_ready=0 in DONE); next word may start the cycle after.
REQ-023 in_valid=0 in COLLECT: no state change; gaps between slices of any length permitted.
REQ-024 Already-written bit fields of out SHALL NOT change while collecting later slices.
REQ-025 zero computed from the registered out word; no combinational path from inputs to out, out_valid, zero.
REQ-026 in_ready depends on state only; out_ready SHALL NOT combinationally affect in_ready.

Reset
REQ-027 rst=1 at a clock edge: state=COLLECT, cnt=0, op_q=00, out=0, out_valid=0; in_ready=1 the cycle after.
REQ-028 rst mid-word or in DONE SHALL discard the partial/held word; no output transfer occurs for it.
REQ-029 rst has priority over simultaneous in/out transfers.

Structure
REQ-030 Shared package/header alu_defs: op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND), NIBBLE_W=4, WORD_W=32.
REQ-031 One combinational sub-module four_bit_logic (a[3:0], b[3:0], op[1:0] -> y[3:0]), single instance driven by current slice.
REQ-032 FSM, counter, op latch and output register SHALL live in serial_nibble_and.

Verification
REQ-033 AND word: A=0xF0F0_1234, B=0xFFFF_00FF, op=00, 8 back-to-back slices -> out=0xF0F0_0034, out_valid 1 cycle after 8th slice, zero=0.
REQ-034 Op latch: A=0xFFFF_FFFF, B=0x0000_0000, op=11 on slice 0 then op=00 on slices 1-7 -> out=0xFFFF_FFFF (NAND throughout).
REQ-035 Zero/backpressure: A=0xAAAA_AAAA, B=0x5555_5555, op=00, out_ready=0 for 5 cycles -> out=0, zero=1, out_valid held, in_ready=0 throughout; in_valid asserted during DONE is ignored.
REQ-036 Gaps: XOR A=0x1234_5678, B=0xFFFF_FFFF with in_valid low 3 cycles between slices -> out=0xEDCB_A987.
REQ-037 Reset mid-word: rst after 4 slices, then full OR word A=0x0000_000F, B=0xF000_0000 -> out=0xF000_000F, no stale nibbles.
REQ-038 Back-to-back words: two words with out_ready=1 -> second word's first slice accepted the cycle after the first output transfer.
